// File: rtl/and32_pkg.sv
// Shared types and constants for the registered 32-bit AND leaf and its 8-bit slices.
// Optional y_zero/y_ones flag logic elsewhere is enabled by AND32_FLAGS_EN.
package and32_pkg;

  localparam int AND32_W       = 32;
  localparam int AND32_SLICE_W = 8;
  localparam int AND32_SLICES  = AND32_W / AND32_SLICE_W;

  typedef logic [AND32_W-1:0]       and32_word_t;
  typedef logic [AND32_SLICE_W-1:0] and32_slice_t;

  localparam and32_word_t AND32_ZERO = '0;
  localparam and32_word_t AND32_ONES = '1;

endpackage

// File: rtl/and32_slice.sv
// Combinational 8-bit bitwise AND; with AND32_FLAGS_EN it also reports
// whether this slice's result is all zeros or all ones.
module and32_slice
  import and32_pkg::*;
(
  input  and32_slice_t a,
  input  and32_slice_t b,
  output and32_slice_t y
`ifdef AND32_FLAGS_EN
  ,
  output logic         zero,
  output logic         ones
`endif
);

  assign y = a & b;

`ifdef AND32_FLAGS_EN
  assign zero = ~|y;
  assign ones = &y;
`endif

endmodule

// File: rtl/and_32.sv
// Registered bitwise AND with valid qualification, 1-cycle latency.
// Define AND32_FLAGS_EN to add the registered y_zero / y_ones flags.
module and_32
  import and32_pkg::*;
#(
  parameter int WIDTH = AND32_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
`ifdef AND32_FLAGS_EN
  ,
  output logic             y_zero,
  output logic             y_ones
`endif
);

  localparam int NSLICE = WIDTH / AND32_SLICE_W;

  logic [WIDTH-1:0] and_p0;
  logic [WIDTH-1:0] y_p1;
  logic             vld_p1;

`ifdef AND32_FLAGS_EN
  logic [NSLICE-1:0] sl_zero_p0;
  logic [NSLICE-1:0] sl_ones_p0;
  logic              zero_p0;
  logic              ones_p0;
  logic              zero_p1;
  logic              ones_p1;
`endif

  // Stage p0: combinational slices
  for (genvar s = 0; s < NSLICE; s++) begin : g_slice
    and32_slice u_slice (
      .a    (a[s*AND32_SLICE_W +: AND32_SLICE_W]),
      .b    (b[s*AND32_SLICE_W +: AND32_SLICE_W]),
      .y    (and_p0[s*AND32_SLICE_W +: AND32_SLICE_W])
`ifdef AND32_FLAGS_EN
      ,
      .zero (sl_zero_p0[s]),
      .ones (sl_ones_p0[s])
`endif
    );
  end

`ifdef AND32_FLAGS_EN
  assign zero_p0 = &sl_zero_p0;
  assign ones_p0 = &sl_ones_p0;
`endif

  // Stage p1: result registers; data only loads on accepted inputs so X on idle cycles never enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        y_p1 <= and_p0;
      end
    end
  end

`ifdef AND32_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_p1 <= 1'b1;
      ones_p1 <= 1'b0;
    end else if (in_valid) begin
      zero_p1 <= zero_p0;
      ones_p1 <= ones_p0;
    end
  end

  assign y_zero = zero_p1;
  assign y_ones = ones_p1;
`endif

  assign out_valid = vld_p1;
  assign y         = y_p1;

endmodule

// File: tb/tb_and_32.sv
// Directed self-checking bench for and_32; flag checks are included when AND32_FLAGS_EN is defined.
module tb_and_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] y;
`ifdef AND32_FLAGS_EN
  logic        y_zero;
  logic        y_ones;
`endif

  int checks   = 0;
  int failures = 0;

  and_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y)
`ifdef AND32_FLAGS_EN
    ,
    .y_zero    (y_zero),
    .y_ones    (y_ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic zero_exp, input logic ones_exp);
`ifdef AND32_FLAGS_EN
    chk({tag, "_zero"}, {31'd0, y_zero}, {31'd0, zero_exp});
    chk({tag, "_ones"}, {31'd0, y_ones}, {31'd0, ones_exp});
`else
    if (zero_exp === ones_exp && zero_exp === 1'bx) $display("%s", tag);
`endif
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic v, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    #2;
    chk("rst_y", y, 32'h0000_0000);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk_flags("rst", 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_hold_y", y, 32'h0000_0000);
    chk("rst_hold_vld", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 32'h0000_0000, 32'h0000_0000);
    chk("zero_y", y, 32'h0000_0000);
    chk("zero_vld", {31'd0, out_valid}, 32'd1);
    chk_flags("zero", 1'b1, 1'b0);

    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ones_y", y, 32'hFFFF_FFFF);
    chk("ones_vld", {31'd0, out_valid}, 32'd1);
    chk_flags("ones", 1'b0, 1'b1);

    step(1'b1, 32'hAAAA_AAAA, 32'h5555_5555);
    chk("b2b1_y", y, 32'h0000_0000);
    chk("b2b1_vld", {31'd0, out_valid}, 32'd1);
    step(1'b1, 32'h0000_FFFF, 32'hFFFF_0000);
    chk("b2b2_y", y, 32'h0000_0000);
    chk("b2b2_vld", {31'd0, out_valid}, 32'd1);
    chk_flags("b2b2", 1'b1, 1'b0);

    step(1'b1, 32'hCCCC_CCCC, 32'hAAAA_AAAA);
    chk("cc_aa_y", y, 32'h8888_8888);
    chk("cc_aa_vld", {31'd0, out_valid}, 32'd1);

    step(1'b0, 32'hxxxx_xxxx, 32'hxxxx_xxxx);
    chk("idle_y_hold", y, 32'h8888_8888);
    chk("idle_vld", {31'd0, out_valid}, 32'd0);
    chk_flags("idle", 1'b0, 1'b0);

    step(1'b1, 32'h1234_5678, 32'h0F0F_0F0F);
    chk("mix_y", y, 32'h0204_0608);
    step(1'b1, 32'h8000_0001, 32'hC000_0003);
    chk("edge_bits_y", y, 32'h8000_0001);
    chk("edge_bits_vld", {31'd0, out_valid}, 32'd1);

    step(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("pre_rst_y", y, 32'hFFFF_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 32'h0000_0000);
    chk("async_rst_vld", {31'd0, out_valid}, 32'd0);
    chk_flags("async_rst", 1'b1, 1'b0);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_y", y, 32'h0000_0000);
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);

    step(1'b1, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
    chk("first_after_rst_y", y, 32'hF0F0_F0F0);
    chk("first_after_rst_vld", {31'd0, out_valid}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
